// File: rtl/bcd_display_pkg.sv
// Shared constants, state type and glyph lookup for the BCD seven-segment display controller.
// Glyphs are active-low with bit0 = segment a.
package bcd_display_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_MINUS = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } stateT;

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return GLYPH_0;
            4'd1:    return GLYPH_1;
            4'd2:    return GLYPH_2;
            4'd3:    return GLYPH_3;
            4'd4:    return GLYPH_4;
            4'd5:    return GLYPH_5;
            4'd6:    return GLYPH_6;
            4'd7:    return GLYPH_7;
            4'd8:    return GLYPH_8;
            4'd9:    return GLYPH_9;
            default: return GLYPH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_if.sv
// Write port and display outputs of the BCD display controller.
interface bcd_display_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
);
    logic                  wr_en;
    logic [WIDTH-1:0]      wr_data;
    logic                  signed_en;
    logic                  blank_en;
    logic [7*DIGITS-1:0]   seg;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    modport master (
        output wr_en, wr_data, signed_en, blank_en,
        input  seg, busy, done, overflow
    );

    modport slave (
        input  wr_en, wr_data, signed_en, blank_en,
        output seg, busy, done, overflow
    );
endinterface

// File: rtl/bcd_display_ctrl_seg7_glyph.sv
// Combinational BCD nibble to active-low seven-segment glyph encoder.
module seg7_glyph
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);
    assign glyph = nibble_to_seg(nibble);
endmodule

// File: rtl/bcd_display_ctrl.sv
// Sequential shift-add-3 binary to BCD converter driving DIGITS seven-segment displays.
// state | meaning:  IDLE | waiting for a write;  CONV | one shift per cycle;  FMT | format and latch seg
module bcd_display_ctrl
    import bcd_display_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input logic            clk,
    input logic            reset,
    bcd_display_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int BCD_W = 4 * DIGITS;

    stateT                 state, stateNext;
    logic [WIDTH-1:0]      shreg;
    logic [BCD_W-1:0]      bcd, bcdAdj;
    logic [CNT_W-1:0]      bitCnt;
    logic                  ovfSticky, negQ, blankQ;
    logic                  pendValid, pendSigned, pendBlank;
    logic [WIDTH-1:0]      pendData;
    logic [7*DIGITS-1:0]   segQ, segNext;
    logic                  doneQ, overflowQ;

    logic                  capValid, capSigned, capBlank, capNeg;
    logic [WIDTH-1:0]      capData, capMag;
    logic                  ovfFinal;
    int                    hiNz;
    logic [6:0]            digitGlyph [DIGITS];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // A direct write always beats a buffered one when both are available in FMT.
    always_comb begin
        stateNext = state;
        capValid  = 1'b0;
        capData   = bus.wr_data;
        capSigned = bus.signed_en;
        capBlank  = bus.blank_en;
        case (state)
            IDLE: begin
                capValid = bus.wr_en;
                if (bus.wr_en) stateNext = CONV;
            end
            CONV: begin
                if (bitCnt == '0) stateNext = FMT;
            end
            FMT: begin
                if (bus.wr_en) begin
                    capValid = 1'b1;
                end else if (pendValid) begin
                    capValid  = 1'b1;
                    capData   = pendData;
                    capSigned = pendSigned;
                    capBlank  = pendBlank;
                end
                stateNext = capValid ? CONV : IDLE;
            end
            default: stateNext = IDLE;
        endcase
        capNeg = capSigned & capData[WIDTH-1];
        capMag = capNeg ? (~capData + WIDTH'(1)) : capData;
    end

    always_comb begin
        bcdAdj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcdAdj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : gGlyph
        seg7_glyph uGlyph (.nibble(bcd[4*k +: 4]), .glyph(digitGlyph[k]));
    end

    // The minus sits just above the highest significant digit; no room for it means overflow.
    always_comb begin
        hiNz    = 0;
        segNext = {DIGITS{GLYPH_BLANK}};
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] != 4'd0) hiNz = k;
        end
        ovfFinal = ovfSticky | (negQ & (hiNz == DIGITS - 1));
        for (int k = 0; k < DIGITS; k++) begin
            if (ovfFinal)                  segNext[7*k +: 7] = GLYPH_MINUS;
            else if (k <= hiNz)            segNext[7*k +: 7] = digitGlyph[k];
            else if (negQ && k == hiNz + 1) segNext[7*k +: 7] = GLYPH_MINUS;
            else if (blankQ)               segNext[7*k +: 7] = GLYPH_BLANK;
            else                           segNext[7*k +: 7] = GLYPH_0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            bcd        <= '0;
            bitCnt     <= '0;
            ovfSticky  <= 1'b0;
            negQ       <= 1'b0;
            blankQ     <= 1'b0;
            pendValid  <= 1'b0;
            pendSigned <= 1'b0;
            pendBlank  <= 1'b0;
            pendData   <= '0;
            segQ       <= {DIGITS{GLYPH_BLANK}};
            doneQ      <= 1'b0;
            overflowQ  <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (capValid) begin
                shreg     <= capMag;
                bcd       <= '0;
                bitCnt    <= CNT_W'(WIDTH - 1);
                ovfSticky <= 1'b0;
                negQ      <= capNeg;
                blankQ    <= capBlank;
            end else if (state == CONV) begin
                {bcd, shreg} <= {bcdAdj, shreg} << 1;
                ovfSticky    <= ovfSticky | bcdAdj[BCD_W-1];
                bitCnt       <= bitCnt - CNT_W'(1);
            end
            if (state == FMT) begin
                segQ      <= segNext;
                overflowQ <= ovfFinal;
                doneQ     <= 1'b1;
                pendValid <= 1'b0;
            end else if (state != IDLE && bus.wr_en) begin
                pendValid  <= 1'b1;
                pendData   <= bus.wr_data;
                pendSigned <= bus.signed_en;
                pendBlank  <= bus.blank_en;
            end
        end
    end

    assign bus.seg      = segQ;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = doneQ;
    assign bus.overflow = overflowQ;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench: decimal-arithmetic display model compared every cycle, plus literal directed cases.
module tb_bcd_display_ctrl;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 4;
    localparam logic [27:0] ALL_BLANK = {4{7'h7F}};
    localparam logic [27:0] ALL_MINUS = {4{7'h3F}};

    logic clk = 1'b0;
    logic reset = 1'b1;

    bcd_display_ctrl_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
    bcd_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit checkEn = 1'b0;

    logic [6:0] glyphTbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bit          mBusy = 0, mPendValid = 0, expDone = 0, expOvf = 0;
    int          mRemain = 0;
    logic [15:0] mJobData = '0, mPendData = '0;
    bit          mJobSgn = 0, mJobBlk = 0, mPendSgn = 0, mPendBlk = 0;
    logic [27:0] expSeg = ALL_BLANK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What the display must show for a value, from decimal digits of its magnitude.
    function automatic logic [27:0] displayOf(input logic [15:0] d, input bit sgn, input bit blk,
                                              output bit ovf);
        int mag, hn, p;
        bit neg;
        int dig [4];
        logic [27:0] r;
        neg = sgn && d[15];
        mag = neg ? 65536 - int'(d) : int'(d);
        ovf = (mag >= 10000);
        p = 1;
        hn = 0;
        for (int k = 0; k < 4; k++) begin
            dig[k] = (mag / p) % 10;
            p = p * 10;
            if (dig[k] != 0) hn = k;
        end
        if (neg && hn == 3) ovf = 1;
        r = ALL_MINUS;
        if (!ovf) begin
            for (int k = 0; k < 4; k++) begin
                if (k <= hn)                 r[7*k +: 7] = glyphTbl[dig[k]];
                else if (neg && k == hn + 1) r[7*k +: 7] = 7'h3F;
                else                         r[7*k +: 7] = blk ? 7'h7F : 7'h40;
            end
        end
        return r;
    endfunction

    task automatic startJob(input logic [15:0] d, input bit s, input bit b);
        mJobData = d;
        mJobSgn  = s;
        mJobBlk  = b;
        mBusy    = 1;
        mRemain  = WIDTH + 1;
    endtask

    task automatic modelEdge();
        bit o;
        if (reset) begin
            mBusy = 0; mPendValid = 0; expSeg = ALL_BLANK; expOvf = 0; expDone = 0;
        end else begin
            expDone = 0;
            if (!mBusy) begin
                if (bus.wr_en) startJob(bus.wr_data, bus.signed_en, bus.blank_en);
            end else begin
                mRemain--;
                if (mRemain == 0) begin
                    expSeg  = displayOf(mJobData, mJobSgn, mJobBlk, o);
                    expOvf  = o;
                    expDone = 1;
                    if (bus.wr_en)     startJob(bus.wr_data, bus.signed_en, bus.blank_en);
                    else if (mPendValid) startJob(mPendData, mPendSgn, mPendBlk);
                    else               mBusy = 0;
                    mPendValid = 0;
                end else if (bus.wr_en) begin
                    mPendValid = 1;
                    mPendData  = bus.wr_data;
                    mPendSgn   = bus.signed_en;
                    mPendBlk   = bus.blank_en;
                end
            end
        end
    endtask

    task automatic cycle(input bit wr, input logic [15:0] d, input bit s, input bit b, input bit rst);
        reset         = rst;
        bus.wr_en     = wr;
        bus.wr_data   = d;
        bus.signed_en = s;
        bus.blank_en  = b;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("model seg", 32'(bus.seg), 32'(expSeg));
            check("model busy", 32'(bus.busy), 32'(mBusy));
            check("model done", 32'(bus.done), 32'(expDone));
            check("model overflow", 32'(bus.overflow), 32'(expOvf));
        end
    end

    task automatic runOne(input string name, input logic [15:0] d, input bit s, input bit b,
                          input logic [27:0] segLit, input bit ovfLit);
        int lat;
        bit seen;
        cycle(1, d, s, b, 0);
        lat = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle(0, 16'h0, 0, 0, 0);
            lat++;
            if (bus.done) seen = 1;
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(WIDTH + 1));
        check({name, " seg"}, 32'(bus.seg), 32'(segLit));
        check({name, " overflow"}, 32'(bus.overflow), 32'(ovfLit));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, doneIdx0, doneIdx1, busyGaps;
        logic [27:0] seg0, seg1;
        bus.wr_en = 0; bus.wr_data = '0; bus.signed_en = 0; bus.blank_en = 0;
        @(negedge clk);
        repeat (3) cycle(0, 16'h0, 0, 0, 1);
        checkEn = 1;
        check("reset seg", 32'(bus.seg), 32'(ALL_BLANK));
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);

        cycle(1, 16'd1234, 0, 0, 0);
        repeat (5) cycle(0, 16'h0, 0, 0, 0);
        repeat (2) cycle(0, 16'h0, 0, 0, 1);
        dn = 0;
        repeat (25) begin
            cycle(0, 16'h0, 0, 0, 0);
            if (bus.done) dn++;
        end
        check("abort done count", 32'(dn), 32'd0);
        check("abort seg", 32'(bus.seg), 32'(ALL_BLANK));
        check("abort busy", 32'(bus.busy), 32'd0);

        runOne("u1234",   16'd1234, 0, 0, {7'h79, 7'h24, 7'h30, 7'h19}, 0);
        runOne("u7 blk",  16'd7,    0, 1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 0);
        runOne("u0 blk",  16'd0,    0, 1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 0);
        runOne("s-7 blk", 16'hFFF9, 1, 1, {7'h7F, 7'h7F, 7'h3F, 7'h78}, 0);
        runOne("s-7",     16'hFFF9, 1, 0, {7'h40, 7'h40, 7'h3F, 7'h78}, 0);
        runOne("u9999",   16'd9999, 0, 1, {7'h10, 7'h10, 7'h10, 7'h10}, 0);
        runOne("s-999",   16'hFC19, 1, 0, {7'h3F, 7'h10, 7'h10, 7'h10}, 0);
        runOne("u12345",  16'd12345, 0, 0, ALL_MINUS, 1);
        runOne("s-1000",  16'hFC18, 1, 1, ALL_MINUS, 1);
        runOne("s-32768", 16'h8000, 1, 0, ALL_MINUS, 1);
        runOne("u1 after ovf", 16'd1, 0, 1, {7'h7F, 7'h7F, 7'h7F, 7'h79}, 0);

        dn = 0; doneIdx0 = -1; doneIdx1 = -1; busyGaps = 0;
        seg0 = '0; seg1 = '0;
        for (int i = 0; i < 45; i++) begin
            if (i == 0)      cycle(1, 16'd5, 0, 0, 0);
            else if (i == 4) cycle(1, 16'd42, 0, 0, 0);
            else if (i == 7) cycle(1, 16'd77, 0, 0, 0);
            else             cycle(0, 16'h0, 0, 0, 0);
            if (bus.done) begin
                if (dn == 0) begin doneIdx0 = i; seg0 = bus.seg; end
                else if (dn == 1) begin doneIdx1 = i; seg1 = bus.seg; end
                dn++;
            end
            if (dn < 2 && !bus.busy) busyGaps++;
        end
        check("b2b done count", 32'(dn), 32'd2);
        check("b2b first seg", 32'(seg0), 32'({7'h40, 7'h40, 7'h40, 7'h12}));
        check("b2b second seg", 32'(seg1), 32'({7'h40, 7'h40, 7'h78, 7'h78}));
        check("b2b first latency", 32'(doneIdx0), 32'(WIDTH + 1));
        check("b2b done spacing", 32'(doneIdx1 - doneIdx0), 32'(WIDTH + 1));
        check("b2b busy gaps", 32'(busyGaps), 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic [15:0] d;
            case ($urandom_range(0, 7))
                0:       d = 16'h8000;
                1:       d = 16'(10000 - $urandom_range(0, 2));
                2:       d = 16'($urandom_range(0, 20));
                3:       d = 16'(16'hFC18 + $urandom_range(0, 2));
                default: d = 16'($urandom_range(0, 65535));
            endcase
            cycle(($urandom_range(0, 9) == 0), d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        repeat (2 * (WIDTH + 2)) cycle(0, 16'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
